// File: rtl/wb_stage.sv
// Write-back stage: owns the register file and flag register F, commits one
// MEM-latch result per unstalled cycle, and serves two bypassed read ports.
module wb_stage #(
    parameter int NREGS = 32,
    parameter int DW    = 16,
    parameter int FW    = 8,
    parameter int CW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [4:0]    Wr_id,
    input  logic [FW-1:0] Fmask,
    input  logic [DW-1:0] Result,
    input  logic [FW-1:0] Flags,
    input  logic          wb_stall,
    input  logic [4:0]    Rd_id_a,
    input  logic [4:0]    Rd_id_b,
    output logic [DW-1:0] Rd_data_a,
    output logic [DW-1:0] Rd_data_b,
    output logic [FW-1:0] F_cur,
    output logic [CW-1:0] retire_cnt,
    output logic          wb_busy
);

    logic [DW-1:0] regs [NREGS];
    logic [FW-1:0] flag_reg;
    logic          commit;
    logic          reg_wr;
    logic [FW-1:0] flag_merged;
    logic          wr_in_range;
    logic          rd_a_in_range;
    logic          rd_b_in_range;

    always_comb begin
        wr_in_range   = 32'(Wr_id) < 32'(NREGS);
        rd_a_in_range = 32'(Rd_id_a) < 32'(NREGS);
        rd_b_in_range = 32'(Rd_id_b) < 32'(NREGS);
        // A reset cycle discards the latch contents, so it never counts as a commit.
        commit        = !RST && !wb_stall && ((Wr_id != '0) || (Fmask != '0));
        reg_wr        = commit && (Wr_id != '0) && wr_in_range;
        flag_merged   = (flag_reg & ~Fmask) | (Flags & Fmask);
    end

    always_comb begin
        Rd_data_a = '0;
        if ((Rd_id_a != '0) && rd_a_in_range) begin
            if (reg_wr && (Rd_id_a == Wr_id))
                Rd_data_a = Result;
            else
                Rd_data_a = regs[Rd_id_a];
        end
    end

    always_comb begin
        Rd_data_b = '0;
        if ((Rd_id_b != '0) && rd_b_in_range) begin
            if (reg_wr && (Rd_id_b == Wr_id))
                Rd_data_b = Result;
            else
                Rd_data_b = regs[Rd_id_b];
        end
    end

    always_comb begin
        F_cur = commit ? flag_merged : flag_reg;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            regs       <= '{default: '0};
            flag_reg   <= '0;
            retire_cnt <= '0;
            wb_busy    <= 1'b0;
        end else begin
            wb_busy <= commit;
            if (commit) begin
                flag_reg   <= flag_merged;
                retire_cnt <= retire_cnt + 1'b1;
            end
            if (reg_wr)
                regs[Wr_id] <= Result;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: reset, write/bypass, null register,
// flag merge, stall hold/release, reset priority and retire counter wrap.
module tb_wb_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  Wr_id;
    logic [7:0]  Fmask;
    logic [15:0] Result;
    logic [7:0]  Flags;
    logic        wb_stall;
    logic [4:0]  Rd_id_a;
    logic [4:0]  Rd_id_b;
    logic [15:0] Rd_data_a;
    logic [15:0] Rd_data_b;
    logic [7:0]  F_cur;
    logic [15:0] retire_cnt;
    logic        wb_busy;

    int vectors = 0;
    int miscompares = 0;

    wb_stage #(.NREGS(32), .DW(16), .FW(8), .CW(16)) dut (
        .CLK(CLK), .RST(RST), .Wr_id(Wr_id), .Fmask(Fmask), .Result(Result),
        .Flags(Flags), .wb_stall(wb_stall), .Rd_id_a(Rd_id_a), .Rd_id_b(Rd_id_b),
        .Rd_data_a(Rd_data_a), .Rd_data_b(Rd_data_b), .F_cur(F_cur),
        .retire_cnt(retire_cnt), .wb_busy(wb_busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Wr_id = '0; Fmask = '0; Result = '0; Flags = '0; wb_stall = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; idle(); Rd_id_a = '0; Rd_id_b = '0;
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Rd_id_a = 5'(i);
            Rd_id_b = 5'(31 - i);
            #1;
            vectors++;
            if (Rd_data_a !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_rd_a[%0d]: got %h expected 0000", i, Rd_data_a);
            end
            vectors++;
            if (Rd_data_b !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_rd_b[%0d]: got %h expected 0000", 31 - i, Rd_data_b);
            end
        end
        vectors++;
        if (F_cur !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_f_cur: got %h expected 00", F_cur);
        end
        vectors++;
        if (retire_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_retire_cnt: got %h expected 0000", retire_cnt);
        end
        vectors++;
        if (wb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wb_busy: got %b expected 0", wb_busy);
        end
    endtask

    task automatic test_write_bypass();
        idle(); Wr_id = 5'd5; Result = 16'h1234; Rd_id_a = 5'd5; Rd_id_b = 5'd5;
        #1;
        vectors++;
        if (Rd_data_a !== 16'h1234) begin
            miscompares++;
            $display("FAIL bypass_rd_a: got %h expected 1234", Rd_data_a);
        end
        vectors++;
        if (Rd_data_b !== 16'h1234) begin
            miscompares++;
            $display("FAIL bypass_rd_b: got %h expected 1234", Rd_data_b);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Rd_data_a !== 16'h1234) begin
            miscompares++;
            $display("FAIL written_rd_a: got %h expected 1234", Rd_data_a);
        end
        vectors++;
        if (retire_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL write_retire_cnt: got %h expected 0001", retire_cnt);
        end
        vectors++;
        if (wb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL write_wb_busy: got %b expected 1", wb_busy);
        end
    endtask

    task automatic test_null_reg();
        idle(); Wr_id = 5'd0; Result = 16'hFFFF; Fmask = 8'h00; Rd_id_b = 5'd0;
        #1;
        vectors++;
        if (Rd_data_b !== 16'h0000) begin
            miscompares++;
            $display("FAIL null_rd_b: got %h expected 0000", Rd_data_b);
        end
        tick();
        #1;
        vectors++;
        if (Rd_data_b !== 16'h0000) begin
            miscompares++;
            $display("FAIL null_rd_b_after: got %h expected 0000", Rd_data_b);
        end
        vectors++;
        if (retire_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL null_retire_cnt: got %h expected 0001", retire_cnt);
        end
        vectors++;
        if (wb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL null_wb_busy: got %b expected 0", wb_busy);
        end
    endtask

    task automatic test_flag_merge();
        idle(); Fmask = 8'hFF; Flags = 8'hA5;
        tick();
        idle();
        #1;
        vectors++;
        if (F_cur !== 8'hA5) begin
            miscompares++;
            $display("FAIL flag_preload: got %h expected a5", F_cur);
        end
        Fmask = 8'h0F; Flags = 8'h3C;
        #1;
        vectors++;
        if (F_cur !== 8'hAC) begin
            miscompares++;
            $display("FAIL flag_merge_comb: got %h expected ac", F_cur);
        end
        tick();
        idle(); Flags = 8'hFF;
        #1;
        vectors++;
        if (F_cur !== 8'hAC) begin
            miscompares++;
            $display("FAIL flag_merge_reg: got %h expected ac", F_cur);
        end
        tick();
        #1;
        vectors++;
        if (F_cur !== 8'hAC) begin
            miscompares++;
            $display("FAIL flag_mask0_hold: got %h expected ac", F_cur);
        end
        vectors++;
        if (retire_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL flag_retire_cnt: got %h expected 0003", retire_cnt);
        end
    endtask

    task automatic test_stall();
        idle(); Wr_id = 5'd7; Result = 16'hBEEF; wb_stall = 1'b1; Rd_id_a = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (Rd_data_a !== 16'h0000) begin
                miscompares++;
                $display("FAIL stall_rd_a[%0d]: got %h expected 0000", c, Rd_data_a);
            end
            tick();
            vectors++;
            if (retire_cnt !== 16'd3) begin
                miscompares++;
                $display("FAIL stall_retire_cnt[%0d]: got %h expected 0003", c, retire_cnt);
            end
            vectors++;
            if (wb_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_wb_busy[%0d]: got %b expected 0", c, wb_busy);
            end
        end
        wb_stall = 1'b0;
        #1;
        vectors++;
        if (Rd_data_a !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL release_bypass: got %h expected beef", Rd_data_a);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Rd_data_a !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL release_reg7: got %h expected beef", Rd_data_a);
        end
        vectors++;
        if (retire_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL release_retire_cnt: got %h expected 0004", retire_cnt);
        end
        vectors++;
        if (wb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL release_wb_busy: got %b expected 1", wb_busy);
        end
        tick();
        vectors++;
        if (retire_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL release_once: got %h expected 0004", retire_cnt);
        end
    endtask

    task automatic test_reset_priority();
        idle(); Wr_id = 5'd3; Result = 16'h1111;
        tick();
        RST = 1'b1; Wr_id = 5'd3; Result = 16'h5555; Fmask = 8'hFF; Flags = 8'hFF;
        Rd_id_a = 5'd3;
        tick();
        RST = 1'b0; idle();
        #1;
        vectors++;
        if (Rd_data_a !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_prio_reg3: got %h expected 0000", Rd_data_a);
        end
        vectors++;
        if (retire_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_prio_retire_cnt: got %h expected 0000", retire_cnt);
        end
        vectors++;
        if (F_cur !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_prio_f_cur: got %h expected 00", F_cur);
        end
        Wr_id = 5'd3; Result = 16'h0042;
        tick();
        idle();
        #1;
        vectors++;
        if (Rd_data_a !== 16'h0042 || retire_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL rst_resume: got reg3=%h cnt=%h expected reg3=0042 cnt=0001",
                     Rd_data_a, retire_cnt);
        end
    endtask

    task automatic test_wrap();
        // retire_cnt is 1 here; 65534 commits bring it to 0xFFFF
        idle(); Wr_id = 5'd1;
        for (int i = 0; i < 65534; i++) begin
            Result = 16'(i);
            tick();
        end
        vectors++;
        if (retire_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: got %h expected ffff", retire_cnt);
        end
        Result = 16'hCAFE; Rd_id_b = 5'd1;
        tick();
        idle();
        #1;
        vectors++;
        if (retire_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_retire_cnt: got %h expected 0000", retire_cnt);
        end
        vectors++;
        if (Rd_data_b !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL wrap_reg1: got %h expected cafe", Rd_data_b);
        end
    endtask

    initial begin
        RST = 1'b1; idle(); Rd_id_a = '0; Rd_id_b = '0;
        test_reset();
        test_write_bypass();
        test_null_reg();
        test_flag_merge();
        test_stall();
        test_reset_priority();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
